// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge: buffered CPU front end for the memory-mapped UART core.
//
// The block is a slave on the CPU native memory bus and a master on the UART
// core's register bus (DATA at 0x0, STATUS at 0x4). A small FSM polls the core,
// drains received bytes into the RX FIFO and feeds queued bytes from the TX FIFO,
// so the CPU never busy-waits and received bytes are not lost.
//
// Ports:
//   clk, reset               clock; asynchronous active-high reset
//   mem_valid/addr/wdata/wstrb  CPU request (wstrb != 0 means write, addr[3:0] decoded)
//   mem_ready, mem_rdata     CPU response (one-cycle ready pulse, registered data)
//   u_valid/addr/wdata/wstrb UART core request (wstrb 4'b0001 write, 4'b0000 read)
//   u_ready, u_rdata         UART core response pulse and read data
//   irq_rx                   level, high while the RX FIFO holds data
//
// Handshakes: both buses use valid/ready pulses. A request stays valid until the
// responder pulses ready for one cycle; the requester drops valid on the same
// edge that samples ready, so a completed request is always followed by at least
// one cycle with valid low and can never be accepted twice.
//
// CPU map: 0x0 W push TX / R pop RX; 0x4 R STATUS; 0x8 W CTRL
// (bit0 clear overflow flags, bit1 flush TX, bit2 flush RX).
module uart_fifo_bridge #(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        u_valid,
    output logic [31:0] u_addr,
    output logic [31:0] u_wdata,
    output logic [3:0]  u_wstrb,
    input  logic        u_ready,
    input  logic [31:0] u_rdata,
    output logic        irq_rx
);

    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int TCW = TAW + 1;
    localparam int RCW = RAW + 1;
    localparam logic [TCW-1:0] TX_FULL_CNT = TCW'(TX_DEPTH);
    localparam logic [RCW-1:0] RX_FULL_CNT = RCW'(RX_DEPTH);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_POLL    = 3'd1;
    localparam logic [2:0] S_RD_DATA = 3'd2;
    localparam logic [2:0] S_WR_DATA = 3'd3;
    localparam logic [2:0] S_GAP     = 3'd4;

    logic [2:0]     state;
    logic           busy_q;      // busy bit from the most recent STATUS poll
    logic           rx_ovf, tx_ovf;

    logic [7:0]     tx_mem [TX_DEPTH];
    logic [TAW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [TCW-1:0] tx_count, tx_count_nxt;
    logic [7:0]     rx_mem [RX_DEPTH];
    logic [RAW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [RCW-1:0] rx_count, rx_count_nxt;

    // CPU request decode
    logic [3:0] a;
    logic       accept, cpu_wr, sel_data, sel_stat, sel_ctrl;
    logic       tx_full, tx_empty, rx_full, rx_empty;
    logic       tx_push, tx_pop, tx_flush, rx_push, rx_push_req, rx_pop, rx_flush;
    logic       ovf_clr, tx_drop, u_done;
    logic [31:0] status, rd_val;

    assign a        = mem_addr[3:0];
    assign accept   = mem_valid && !mem_ready;
    assign cpu_wr   = |mem_wstrb;
    assign sel_data = (a == 4'h0);
    assign sel_stat = (a == 4'h4);
    assign sel_ctrl = (a == 4'h8);

    assign tx_full  = (tx_count == TX_FULL_CNT);
    assign tx_empty = (tx_count == '0);
    assign rx_full  = (rx_count == RX_FULL_CNT);
    assign rx_empty = (rx_count == '0);

    assign ovf_clr  = accept && cpu_wr && sel_ctrl && mem_wdata[0];
    assign tx_flush = accept && cpu_wr && sel_ctrl && mem_wdata[1];
    assign rx_flush = accept && cpu_wr && sel_ctrl && mem_wdata[2];
    assign tx_push  = accept && cpu_wr && sel_data && !tx_full;
    assign tx_drop  = accept && cpu_wr && sel_data && tx_full;
    assign rx_pop   = accept && !cpu_wr && sel_data && !rx_empty;

    assign u_done      = u_valid && u_ready;
    // A flush in the same cycle wins over the pop, so the FSM then skips the write.
    assign tx_pop      = (state == S_POLL) && u_done && !u_rdata[0] && !u_rdata[1]
                         && !tx_empty && !tx_flush;
    assign rx_push_req = (state == S_RD_DATA) && u_done;
    assign rx_push     = rx_push_req && !rx_full;

    assign tx_count_nxt = tx_flush ? '0 : tx_count + TCW'(tx_push) - TCW'(tx_pop);
    assign rx_count_nxt = rx_flush ? '0 : rx_count + RCW'(rx_push) - RCW'(rx_pop);

    assign status = {8'h00, 8'(tx_count), 8'(rx_count), 3'b000, tx_ovf, rx_ovf,
                     (tx_empty && !busy_q), tx_full, !rx_empty};

    always_comb begin
        rd_val = '0;
        if (!cpu_wr) begin
            if (sel_data && !rx_empty) rd_val = {24'h0, rx_mem[rx_rd_ptr]};
            else if (sel_stat)         rd_val = status;
        end
    end

    // FIFO storage carries no reset; only pointers and counts define contents.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= mem_wdata[7:0];
        if (rx_push) rx_mem[rx_wr_ptr] <= u_rdata[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
            irq_rx    <= 1'b0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            tx_ovf    <= 1'b0;
            rx_ovf    <= 1'b0;
        end else begin
            tx_count <= tx_count_nxt;
            rx_count <= rx_count_nxt;
            irq_rx   <= (rx_count_nxt != '0);
            if (tx_flush) begin
                tx_wr_ptr <= '0;
                tx_rd_ptr <= '0;
            end else begin
                if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
                if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
            end
            if (rx_flush) begin
                rx_wr_ptr <= '0;
                rx_rd_ptr <= '0;
            end else begin
                if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
                if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
            end
            mem_ready <= accept;
            if (accept) mem_rdata <= rd_val;
            // A new overflow in the same cycle as a clear is kept.
            if (ovf_clr) begin
                tx_ovf <= 1'b0;
                rx_ovf <= 1'b0;
            end
            if (tx_drop) tx_ovf <= 1'b1;
            if (rx_push_req && rx_full) rx_ovf <= 1'b1;
        end
    end

    // UART master. POLL is entered with u_valid already high; RD_DATA/WR_DATA
    // spend their first cycle with u_valid low, which gives the post-POLL gap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            busy_q  <= 1'b0;
            u_valid <= 1'b0;
            u_addr  <= '0;
            u_wdata <= '0;
            u_wstrb <= '0;
        end else begin
            case (state)
                S_IDLE, S_GAP: begin
                    state   <= S_POLL;
                    u_valid <= 1'b1;
                    u_addr  <= 32'h4;
                    u_wstrb <= 4'b0000;
                end
                S_POLL: begin
                    if (u_done) begin
                        u_valid <= 1'b0;
                        busy_q  <= u_rdata[1];
                        if (u_rdata[0]) begin
                            state   <= S_RD_DATA;
                            u_addr  <= 32'h0;
                            u_wstrb <= 4'b0000;
                        end else if (tx_pop) begin
                            state   <= S_WR_DATA;
                            u_addr  <= 32'h0;
                            u_wstrb <= 4'b0001;
                            u_wdata <= {24'h0, tx_mem[tx_rd_ptr]};
                        end else begin
                            state <= S_GAP;
                        end
                    end
                end
                S_RD_DATA, S_WR_DATA: begin
                    if (!u_valid) begin
                        u_valid <= 1'b1;
                    end else if (u_ready) begin
                        u_valid <= 1'b0;
                        state   <= S_GAP;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    u_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Self-checking bench for uart_fifo_bridge: a UART core model on the master
// side logs every access, and each scenario task compares CPU-visible results
// and the logged UART traffic against expectations built from byte queues.
module tb_uart_fifo_bridge;

    localparam int TX_DEPTH = 16;
    localparam int RX_DEPTH = 16;
    localparam logic [7:0] EV_POLL = 8'd1;
    localparam logic [7:0] EV_RD   = 8'd2;
    localparam logic [7:0] EV_WR   = 8'd3;
    localparam logic [7:0] EV_BAD  = 8'hff;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        u_valid;
    logic [31:0] u_addr;
    logic [31:0] u_wdata;
    logic [3:0]  u_wstrb;
    logic        u_ready = 1'b0;
    logic [31:0] u_rdata = '0;
    logic        irq_rx;

    int checks = 0;
    int errors = 0;

    // UART core model state
    logic        m_busy = 1'b0;
    bit          m_busy_rand = 1'b0;
    logic        mb;
    logic [7:0]  mbyte;
    int          u_wait = 0;
    int          gap_viol = 0;
    logic [7:0]  rx_src[$];        // bytes the core will deliver
    logic [15:0] ev_q[$];          // {type, byte} log of core accesses
    logic [7:0]  exp_q[$];         // expected byte stream

    uart_fifo_bridge #(.TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) dut (
        .clk(clk), .reset(rst),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .u_valid(u_valid), .u_addr(u_addr), .u_wdata(u_wdata), .u_wstrb(u_wstrb),
        .u_ready(u_ready), .u_rdata(u_rdata), .irq_rx(irq_rx)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- UART core model ----------------
    always @(negedge clk) begin
        if (rst) begin
            u_ready = 1'b0;
            u_wait  = 0;
        end else if (u_ready) begin
            u_ready = 1'b0;
        end else if (u_valid) begin
            if (u_wait > 0) begin
                u_wait--;
            end else begin
                u_ready = 1'b1;
                u_wait  = $urandom_range(0, 2);
                u_rdata = $urandom;
                if (u_addr == 32'h4 && u_wstrb == 4'b0000) begin
                    mb = m_busy_rand ? 1'($urandom_range(0, 1)) : m_busy;
                    u_rdata[1:0] = {mb, (rx_src.size() != 0)};
                    ev_q.push_back({EV_POLL, 8'h00});
                end else if (u_addr == 32'h0 && u_wstrb == 4'b0000) begin
                    mbyte = (rx_src.size() != 0) ? rx_src.pop_front() : 8'h00;
                    u_rdata[7:0] = mbyte;
                    ev_q.push_back({EV_RD, mbyte});
                end else if (u_addr == 32'h0 && u_wstrb == 4'b0001 && u_wdata[31:8] == 24'h0) begin
                    ev_q.push_back({EV_WR, u_wdata[7:0]});
                end else begin
                    ev_q.push_back({EV_BAD, u_wdata[7:0]});
                end
            end
        end
    end

    // A request must never still be valid right after the edge that took ready.
    always @(posedge clk) begin
        if (!rst && u_ready && u_valid) begin
            #1;
            if (u_valid && !rst) gap_viol++;
        end
    end

    // ---------------- helpers / drivers ----------------
    function automatic int count_ev(logic [7:0] t);
        int n = 0;
        foreach (ev_q[i]) if (ev_q[i][15:8] == t) n++;
        return n;
    endfunction

    function automatic logic [31:0] status_word(int rxc, int txc, bit idle, bit rovf, bit tovf);
        return {8'h00, 8'(txc), 8'(rxc), 3'b000, tovf, rovf, idle, (txc == TX_DEPTH), (rxc != 0)};
    endfunction

    task automatic cpu_access(input logic [3:0] a, input logic [31:0] wd,
                              input logic [3:0] ws, output logic [31:0] rd);
        int n;
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = {28'($urandom), a};
        mem_wdata = wd;
        mem_wstrb = ws;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!mem_ready && n < 20);
        checks++;
        if (!mem_ready) begin
            errors++;
            $display("FAIL cpu_ready: no mem_ready within 20 cycles, addr=%h", a);
        end
        rd = mem_rdata;
        mem_valid = 1'b0;
        mem_wstrb = 4'b0000;
    endtask

    task automatic cpu_write(input logic [3:0] a, input logic [7:0] b);
        logic [31:0] wd, rd;
        wd = $urandom;
        wd[7:0] = b;
        cpu_access(a, wd, 4'($urandom_range(1, 15)), rd);
    endtask

    task automatic cpu_read(input logic [3:0] a, output logic [31:0] rd);
        cpu_access(a, $urandom, 4'b0000, rd);
    endtask

    task automatic wait_ev(input logic [7:0] t, input int n, input int budget, input string name);
        int c = 0;
        while (count_ev(t) < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        checks++;
        if (count_ev(t) < n) begin
            errors++;
            $display("FAIL %s: saw %0d events of type %0d, required %0d", name, count_ev(t), t, n);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] rd;
        int c;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({mem_ready, mem_rdata, irq_rx} !== '0) begin
            errors++;
            $display("FAIL reset_cpu_side: got ready=%b rdata=%h irq=%b, required all 0", mem_ready, mem_rdata, irq_rx);
        end
        checks++;
        if ({u_valid, u_addr, u_wdata, u_wstrb} !== '0) begin
            errors++;
            $display("FAIL reset_uart_side: got valid=%b addr=%h wdata=%h wstrb=%b, required all 0", u_valid, u_addr, u_wdata, u_wstrb);
        end
        @(negedge clk);
        rst = 1'b0;
        c = 0;
        while (!u_valid && c < 10) begin
            @(posedge clk);
            #1;
            c++;
        end
        checks++;
        if (u_valid !== 1'b1 || u_addr !== 32'h4 || u_wstrb !== 4'b0000) begin
            errors++;
            $display("FAIL first_poll: got valid=%b addr=%h wstrb=%b, required 1 / 00000004 / 0000", u_valid, u_addr, u_wstrb);
        end
        cpu_read(4'h4, rd);
        checks++;
        if (rd !== 32'h0000_0004) begin
            errors++;
            $display("FAIL reset_status: got %h, required 00000004", rd);
        end
        wait_ev(EV_POLL, 3, 200, "idle_polls");
        checks++;
        if (count_ev(EV_POLL) != ev_q.size()) begin
            errors++;
            $display("FAIL idle_only_polls: got %0d events, %0d polls, required all polls", ev_q.size(), count_ev(EV_POLL));
        end
    endtask

    task automatic check_tx_stream(input string name);
        logic [7:0] b;
        foreach (ev_q[i]) begin
            if (ev_q[i][15:8] == EV_WR) begin
                b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
                checks++;
                if (ev_q[i][7:0] !== b || i == 0 || ev_q[i-1][15:8] != EV_POLL) begin
                    errors++;
                    $display("FAIL %s_byte: got %h at event %0d, required %h preceded by a poll", name, ev_q[i][7:0], i, b);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing: %0d bytes never written, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_tx_basic();
        logic [31:0] rd;
        logic [7:0] bytes [3];
        bytes = '{8'h41, 8'h42, 8'h43};
        m_busy = 1'b0;
        ev_q.delete();
        exp_q.delete();
        repeat (3) @(posedge clk);
        foreach (bytes[i]) begin
            exp_q.push_back(bytes[i]);
            cpu_write(4'h0, bytes[i]);
        end
        wait_ev(EV_WR, 3, 1000, "tx_basic_wait");
        repeat (10) @(posedge clk);
        checks++;
        if (count_ev(EV_WR) != 3 || count_ev(EV_BAD) != 0) begin
            errors++;
            $display("FAIL tx_basic_count: got %0d writes %0d bad, required 3 and 0", count_ev(EV_WR), count_ev(EV_BAD));
        end
        check_tx_stream("tx_basic");
        cpu_read(4'h4, rd);
        checks++;
        if (rd !== status_word(0, 0, 1, 0, 0)) begin
            errors++;
            $display("FAIL tx_basic_status: got %h, required %h", rd, status_word(0, 0, 1, 0, 0));
        end
    endtask

    task automatic test_tx_random();
        logic [31:0] rd;
        logic [7:0] b;
        int n;
        n = $urandom_range(4, 12);
        m_busy_rand = 1'b1;
        ev_q.delete();
        exp_q.delete();
        repeat (3) @(posedge clk);
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            cpu_write(4'h0, b);
        end
        wait_ev(EV_WR, n, 4000, "tx_random_wait");
        m_busy_rand = 1'b0;
        repeat (20) @(posedge clk);
        check_tx_stream("tx_random");
        cpu_read(4'h4, rd);
        checks++;
        if (rd[23:16] !== 8'd0 || rd[4] !== 1'b0) begin
            errors++;
            $display("FAIL tx_random_status: got tx_count=%0d tx_ovf=%b, required 0 and 0", rd[23:16], rd[4]);
        end
    endtask

    task automatic test_rx_basic();
        logic [31:0] rd;
        ev_q.delete();
        rx_src.push_back(8'h55);
        rx_src.push_back(8'hAA);
        wait_ev(EV_RD, 2, 500, "rx_basic_wait");
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (irq_rx !== 1'b1) begin
            errors++;
            $display("FAIL rx_basic_irq: got %b, required 1", irq_rx);
        end
        cpu_read(4'h4, rd);
        checks++;
        if (rd !== status_word(2, 0, 1, 0, 0)) begin
            errors++;
            $display("FAIL rx_basic_status: got %h, required %h", rd, status_word(2, 0, 1, 0, 0));
        end
        cpu_read(4'h0, rd);
        checks++;
        if (rd !== 32'h55 || irq_rx !== 1'b1) begin
            errors++;
            $display("FAIL rx_basic_pop1: got %h irq=%b, required 00000055 irq=1", rd, irq_rx);
        end
        cpu_read(4'h0, rd);
        checks++;
        if (rd !== 32'hAA || irq_rx !== 1'b0) begin
            errors++;
            $display("FAIL rx_basic_pop2: got %h irq=%b, required 000000aa irq=0", rd, irq_rx);
        end
        cpu_read(4'h0, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL rx_empty_read: got %h, required 00000000", rd);
        end
    endtask

    task automatic test_rx_random();
        logic [31:0] rd;
        logic [7:0] b;
        int n;
        n = $urandom_range(2, 10);
        ev_q.delete();
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            rx_src.push_back(b);
            exp_q.push_back(b);
        end
        wait_ev(EV_RD, n, 2000, "rx_random_wait");
        repeat (5) @(posedge clk);
        cpu_read(4'h4, rd);
        checks++;
        if (rd !== status_word(n, 0, 1, 0, 0)) begin
            errors++;
            $display("FAIL rx_random_status: got %h, required %h", rd, status_word(n, 0, 1, 0, 0));
        end
        for (int i = 0; i < n; i++) begin
            b = exp_q.pop_front();
            cpu_read(4'h0, rd);
            checks++;
            if (rd !== {24'h0, b}) begin
                errors++;
                $display("FAIL rx_random_data: got %h, required %h", rd, {24'h0, b});
            end
        end
        // fill a few more, then flush the RX FIFO through CTRL
        ev_q.delete();
        for (int i = 0; i < 3; i++) rx_src.push_back(8'($urandom));
        wait_ev(EV_RD, 3, 1000, "rx_flush_wait");
        repeat (5) @(posedge clk);
        cpu_write(4'h8, 8'h04);
        cpu_read(4'h4, rd);
        checks++;
        if (rd !== status_word(0, 0, 1, 0, 0) || irq_rx !== 1'b0) begin
            errors++;
            $display("FAIL rx_flush: got status %h irq=%b, required %h irq=0", rd, irq_rx, status_word(0, 0, 1, 0, 0));
        end
    endtask

    task automatic test_tx_overflow();
        logic [31:0] rd;
        m_busy = 1'b1;
        repeat (20) @(posedge clk);
        ev_q.delete();
        for (int i = 0; i < TX_DEPTH + 1; i++) cpu_write(4'h0, 8'($urandom));
        repeat (10) @(posedge clk);
        cpu_read(4'h4, rd);
        checks++;
        if (rd !== status_word(0, TX_DEPTH, 0, 0, 1)) begin
            errors++;
            $display("FAIL tx_ovf_status: got %h, required %h", rd, status_word(0, TX_DEPTH, 0, 0, 1));
        end
        cpu_write(4'h8, 8'h03);
        cpu_read(4'h4, rd);
        checks++;
        if (rd !== status_word(0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL tx_flush_status: got %h, required %h", rd, status_word(0, 0, 0, 0, 0));
        end
        m_busy = 1'b0;
        repeat (30) @(posedge clk);
        checks++;
        if (count_ev(EV_WR) != 0) begin
            errors++;
            $display("FAIL tx_flush_no_writes: got %0d writes, required 0", count_ev(EV_WR));
        end
    endtask

    task automatic test_rx_overflow();
        logic [31:0] rd;
        logic [7:0] b;
        ev_q.delete();
        exp_q.delete();
        for (int i = 0; i < RX_DEPTH + 1; i++) begin
            b = 8'($urandom);
            rx_src.push_back(b);
            if (i < RX_DEPTH) exp_q.push_back(b);
        end
        wait_ev(EV_RD, RX_DEPTH + 1, 4000, "rx_ovf_wait");
        repeat (10) @(posedge clk);
        checks++;
        if (count_ev(EV_RD) != RX_DEPTH + 1) begin
            errors++;
            $display("FAIL rx_ovf_core_reads: got %0d, required %0d", count_ev(EV_RD), RX_DEPTH + 1);
        end
        cpu_read(4'h4, rd);
        checks++;
        if (rd !== status_word(RX_DEPTH, 0, 1, 1, 0)) begin
            errors++;
            $display("FAIL rx_ovf_status: got %h, required %h", rd, status_word(RX_DEPTH, 0, 1, 1, 0));
        end
        for (int i = 0; i < RX_DEPTH; i++) begin
            b = exp_q.pop_front();
            cpu_read(4'h0, rd);
            checks++;
            if (rd !== {24'h0, b}) begin
                errors++;
                $display("FAIL rx_ovf_data: entry %0d got %h, required %h", i, rd, {24'h0, b});
            end
        end
        cpu_read(4'h4, rd);
        checks++;
        if (rd !== status_word(0, 0, 1, 1, 0)) begin
            errors++;
            $display("FAIL rx_ovf_sticky: got %h, required %h", rd, status_word(0, 0, 1, 1, 0));
        end
        cpu_write(4'h8, 8'h01);
        cpu_read(4'h4, rd);
        checks++;
        if (rd !== status_word(0, 0, 1, 0, 0)) begin
            errors++;
            $display("FAIL ovf_clear: got %h, required %h", rd, status_word(0, 0, 1, 0, 0));
        end
    endtask

    task automatic test_priority();
        logic [31:0] rd;
        int first_rd, first_wr;
        m_busy = 1'b1;
        repeat (20) @(posedge clk);
        cpu_write(4'h0, 8'h5A);
        repeat (20) @(posedge clk);
        #1;
        ev_q.delete();
        rx_src.push_back(8'h77);
        m_busy = 1'b0;
        wait_ev(EV_WR, 1, 500, "priority_wait");
        repeat (5) @(posedge clk);
        first_rd = -1;
        first_wr = -1;
        foreach (ev_q[i]) begin
            if (ev_q[i][15:8] == EV_RD && first_rd < 0) first_rd = i;
            if (ev_q[i][15:8] == EV_WR && first_wr < 0) first_wr = i;
        end
        checks++;
        if (first_rd < 0 || first_wr < 0 || first_rd > first_wr) begin
            errors++;
            $display("FAIL rx_priority: rd at %0d wr at %0d, required rd before wr", first_rd, first_wr);
        end
        checks++;
        if (first_wr < 0 || ev_q[first_wr][7:0] !== 8'h5A) begin
            errors++;
            $display("FAIL priority_tx_byte: got index %0d, required byte 5a written", first_wr);
        end
        cpu_read(4'h0, rd);
        checks++;
        if (rd !== 32'h77) begin
            errors++;
            $display("FAIL priority_rx_byte: got %h, required 00000077", rd);
        end
    endtask

    task automatic test_reset_midway();
        logic [31:0] rd;
        int c;
        m_busy = 1'b0;
        rx_src.push_back(8'h33);
        c = 0;
        while (!irq_rx && c < 300) begin
            @(posedge clk);
            c++;
        end
        cpu_write(4'h0, 8'h99);
        cpu_write(4'h0, 8'h9A);
        cpu_write(4'h0, 8'h9B);
        c = 0;
        do begin
            @(posedge clk);
            #1;
            c++;
        end while (!(u_valid && u_wstrb == 4'b0001) && c < 300);
        checks++;
        if (!(u_valid && u_wstrb == 4'b0001)) begin
            errors++;
            $display("FAIL reset_mid_setup: never saw a WR_DATA request, valid=%b wstrb=%b", u_valid, u_wstrb);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (u_valid !== 1'b0 || u_wstrb !== 4'b0000) begin
            errors++;
            $display("FAIL reset_async: got valid=%b wstrb=%b, required 0 / 0000", u_valid, u_wstrb);
        end
        repeat (2) @(posedge clk);
        ev_q.delete();
        @(negedge clk);
        rst = 1'b0;
        wait_ev(EV_POLL, 1, 50, "post_reset_poll");
        checks++;
        if (ev_q.size() == 0 || ev_q[0][15:8] != EV_POLL) begin
            errors++;
            $display("FAIL post_reset_first: got %0d events, required first event to be a poll", ev_q.size());
        end
        repeat (30) @(posedge clk);
        checks++;
        if (count_ev(EV_POLL) != ev_q.size()) begin
            errors++;
            $display("FAIL post_reset_traffic: got %0d non-poll events, required 0", ev_q.size() - count_ev(EV_POLL));
        end
        cpu_read(4'h4, rd);
        checks++;
        if (rd !== status_word(0, 0, 1, 0, 0) || irq_rx !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_status: got %h irq=%b, required %h irq=0", rd, irq_rx, status_word(0, 0, 1, 0, 0));
        end
    endtask

    task automatic test_gap();
        checks++;
        if (gap_viol != 0) begin
            errors++;
            $display("FAIL u_valid_gap: got %0d back-to-back requests, required 0", gap_viol);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_tx_basic();
        test_tx_random();
        test_rx_basic();
        test_rx_random();
        test_tx_overflow();
        test_rx_overflow();
        test_priority();
        test_reset_midway();
        test_gap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_fifo_bridge.md
Name: uart_fifo_bridge

Overview:
- Buffered CPU front end for the memory-mapped UART core.
- Acts as a slave on the CPU native memory bus and as a bus master on the UART core's register bus (DATA at 0x0, STATUS at 0x4).
- Autonomously polls the UART core: drains received bytes into an RX FIFO and feeds queued bytes from a TX FIFO.
- Removes CPU busy-waiting and rx byte loss.

Parameters:
- TX_DEPTH, 16, TX FIFO entries; power of two, 2..128.
- RX_DEPTH, 16, RX FIFO entries; power of two, 2..128.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- mem_valid  in  1  CPU request valid
- mem_addr  in  32  CPU address; only [3:0] decoded
- mem_wdata  in  32  CPU write data
- mem_wstrb  in  4  CPU byte strobes; nonzero = write
- mem_ready  out  1  CPU response pulse
- mem_rdata  out  32  CPU read data
- u_valid  out  1  request to UART core
- u_addr  out  32  UART core register address (0x0 or 0x4)
- u_wdata  out  32  UART core write data
- u_wstrb  out  4  UART core strobes (4'b0001 write, 4'b0000 read)
- u_ready  in  1  UART core response pulse
- u_rdata  in  32  UART core read data
- irq_rx  out  1  level: RX FIFO non-empty

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values:
  - mem_ready=0, mem_rdata=0, u_valid=0, u_addr=0, u_wdata=0, u_wstrb=0, irq_rx=0.
  - Both FIFOs empty; both sticky flags cleared; FSM in IDLE.
  - Reset mid-transaction abandons any in-flight UART access; a byte already popped from the TX FIFO is lost.
- CPU slave handshake:
  - A request is accepted when mem_valid && !mem_ready.
  - mem_ready pulses high for exactly one cycle, on the edge after acceptance.
  - mem_rdata is updated on that same edge.
  - Undecoded addresses: ready with mem_rdata=0.
- CPU register map:
  - 0x0 write: push mem_wdata[7:0] into the TX FIFO. If the FIFO is full (evaluated before the edge, even if a pop occurs that cycle), drop the byte and set tx_ovf.
  - 0x0 read: mem_rdata = {24'b0, RX head} and pop. If the RX FIFO is empty, return 0 and do not pop.
  - 0x4 read (STATUS):
    - bit0 rx_nonempty
    - bit1 tx_full
    - bit2 tx_idle: TX FIFO empty and last polled UART busy bit = 0
    - bit3 rx_ovf
    - bit4 tx_ovf
    - [15:8] rx_count
    - [23:16] tx_count
    - all other bits 0
  - 0x8 write (CTRL): bit0=1 clears rx_ovf and tx_ovf; bit1=1 flushes the TX FIFO; bit2=1 flushes the RX FIFO. Reads of 0x8 return 0.
  - Flush beats a same-cycle push or pop on the same FIFO.
- UART master FSM:
  - States: IDLE, POLL, RD_DATA, WR_DATA, GAP.
  - IDLE goes to POLL unconditionally.
  - POLL: u_valid=1, u_addr=0x4, u_wstrb=0. On u_ready, latch u_rdata[1:0] as {busy, rxrdy} and decide:
    - rxrdy=1 goes to RD_DATA (RX has priority over TX).
    - else, TX FIFO non-empty and busy=0 goes to WR_DATA. The TX head is popped on this transition and latched into u_wdata[7:0], with upper bits 0.
    - otherwise goes to GAP.
  - RD_DATA: u_addr=0x0, u_wstrb=0. On u_ready, push u_rdata[7:0] into the RX FIFO. If the RX FIFO is full, drop the byte and set rx_ovf (the read still clears the core's flag). Then go to GAP.
  - WR_DATA: u_addr=0x0, u_wstrb=4'b0001. On u_ready go to GAP. A CTRL flush does not cancel a byte already latched.
  - GAP: u_valid=0 for one cycle, then go to POLL.
  - u_valid drops on the same edge that samples u_ready=1. Every transaction is therefore followed by at least one low cycle, so the core never re-accepts a request.
- FIFO rules:
  - Pointers wrap modulo DEPTH.
  - Counts are clog2(DEPTH)+1 bits, zero-extended into STATUS.
  - A simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
  - RX push and CPU pop in the same cycle with count=0: the CPU read returns 0 and the pushed byte is retained.
- irq_rx: registered; equals rx_count != 0 after each edge.

Test Plan:
- Reset then CPU reads 0x4 -> mem_rdata=0x00000004 (tx_idle only); u_valid starts POLL cycles at 0x4 with a GAP cycle between each.
- CPU writes 0x41, 0x42, 0x43 to 0x0 with the UART model reporting busy=0 -> exactly three u_wstrb=0001 writes carrying 0x41, 0x42, 0x43 in order, each preceded by a STATUS poll; tx_count returns to 0.
- UART model presents rxrdy with bytes 0x55 then 0xAA -> irq_rx=1; STATUS [15:8]=2; CPU reads 0x0 twice -> 0x55, 0xAA; irq_rx drops the cycle after the second pop.
- Write TX_DEPTH+1 bytes while the model holds busy=1 -> tx_full=1, tx_ovf=1, tx_count=16; CTRL write 0x3 -> tx_count=0, flags clear, no UART writes issued.
- RX FIFO filled with 16 bytes, model supplies a 17th -> rx_ovf=1, the 17th is not stored, the core is still read at 0x0 once; rxrdy and TX pending together -> RD_DATA is issued before WR_DATA.
- Assert reset while u_valid=1 in WR_DATA -> u_valid=0 immediately (asynchronously); after release the FIFOs are empty and the first transaction is a POLL.
